complex_mag_est: RTL and testbench

//  Pipelined alpha-max-plus-beta-min magnitude estimator for signed I/Q samples.

---
 rtl/complex_mag_est_pkg.sv | 14 +
 rtl/complex_mag_est_abs_sat.sv | 22 ++
 rtl/complex_mag_est.sv | 188 ++++++++++++++++++
 tb/tb_complex_mag_est.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/complex_mag_est_pkg.sv
// Shared definitions for the complex magnitude estimator.
// Mode encodings and pipeline latency.
package complex_mag_est_pkg;

    typedef enum logic [1:0] {
        MODE_A1_B4  = 2'd0,
        MODE_A1_B2  = 2'd1,
        MODE_A15_16 = 2'd2,
        MODE_BEST2  = 2'd3
    } mode_e;

    localparam int LATENCY = 4;

endpackage

// File: rtl/complex_mag_est_abs_sat.sv
// Combinational saturating absolute value.
// The most negative input maps to the largest positive value.
module abs_sat #(
    parameter int DATA_WIDTH = 16
) (
    input  logic signed [DATA_WIDTH-1:0] x,
    output logic        [DATA_WIDTH-1:0] y
);

    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    // Negate negatives; clamp the one value whose negation overflows.
    always_comb begin
        y = x;
        if (x == MIN_NEG)
            y = MAX_POS;
        else if (x[DATA_WIDTH-1])
            y = ~x + 1'b1;
    end

endmodule

// File: rtl/complex_mag_est.sv
// Four-stage alpha-max-plus-beta-min magnitude estimator.
// Per-sample mode and tag ride a valid chain; peak-hold on output.
module complex_mag_est
    import complex_mag_est_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int TAG_WIDTH  = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] i,
    input  logic [DATA_WIDTH-1:0] q,
    input  logic [1:0]            mode,
    input  logic [TAG_WIDTH-1:0]  tag_in,
    input  logic                  input_valid,
    input  logic                  peak_clear,
    output logic [DATA_WIDTH:0]   mag,
    output logic                  mag_stb,
    output logic [TAG_WIDTH-1:0]  tag_out,
    output logic [DATA_WIDTH:0]   peak
);

    localparam int W = DATA_WIDTH;

    logic [W-1:0] abs_i;
    logic [W-1:0] abs_q;

    abs_sat #(.DATA_WIDTH(W)) u_abs_i (
        .x (i),
        .y (abs_i)
    );

    abs_sat #(.DATA_WIDTH(W)) u_abs_q (
        .x (q),
        .y (abs_q)
    );

    // Stage 1: magnitudes of each rail
    logic                 s1_v;
    mode_e                s1_mode;
    logic [TAG_WIDTH-1:0] s1_tag;
    logic [W-1:0]         s1_ai;
    logic [W-1:0]         s1_aq;

    // Stage 2: ordered pair
    logic                 s2_v;
    mode_e                s2_mode;
    logic [TAG_WIDTH-1:0] s2_tag;
    logic [W-1:0]         s2_mx;
    logic [W-1:0]         s2_mn;

    // Stage 3: scaled terms, primary and alternate estimator
    logic                 s3_v;
    logic [TAG_WIDTH-1:0] s3_tag;
    logic [W-1:0]         s3_a0;
    logic [W-1:0]         s3_b0;
    logic [W-1:0]         s3_a1;
    logic [W-1:0]         s3_b1;

    logic [W-1:0] a0_c;
    logic [W-1:0] b0_c;
    logic [W-1:0] a1_c;
    logic [W-1:0] b1_c;
    logic [W:0]   sum0;
    logic [W:0]   sum1;
    logic [W:0]   est;

    // Stage 1 register: absolute values plus sample side-band
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_v    <= 1'b0;
            s1_mode <= MODE_A1_B4;
            s1_tag  <= '0;
            s1_ai   <= '0;
            s1_aq   <= '0;
        end else if (enable) begin
            s1_v    <= input_valid;
            s1_mode <= mode_e'(mode);
            s1_tag  <= tag_in;
            s1_ai   <= abs_i;
            s1_aq   <= abs_q;
        end
    end

    // Stage 2 register: sort into max and min
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s2_v    <= 1'b0;
            s2_mode <= MODE_A1_B4;
            s2_tag  <= '0;
            s2_mx   <= '0;
            s2_mn   <= '0;
        end else if (enable) begin
            s2_v    <= s1_v;
            s2_mode <= s1_mode;
            s2_tag  <= s1_tag;
            if (s1_ai >= s1_aq) begin
                s2_mx <= s1_ai;
                s2_mn <= s1_aq;
            end else begin
                s2_mx <= s1_aq;
                s2_mn <= s1_ai;
            end
        end
    end

    // Shift-and-subtract terms; alternate pair is zero unless best-of-two
    always_comb begin
        a0_c = s2_mx;
        b0_c = s2_mn >> 2;
        a1_c = '0;
        b1_c = '0;
        case (s2_mode)
            MODE_A1_B4: begin
                a0_c = s2_mx;
                b0_c = s2_mn >> 2;
            end
            MODE_A1_B2: begin
                a0_c = s2_mx;
                b0_c = s2_mn >> 1;
            end
            MODE_A15_16: begin
                a0_c = s2_mx - (s2_mx >> 4);
                b0_c = (s2_mn >> 1) - (s2_mn >> 5);
            end
            MODE_BEST2: begin
                a0_c = s2_mx;
                b0_c = s2_mn >> 2;
                a1_c = s2_mx - (s2_mx >> 3);
                b1_c = s2_mn >> 1;
            end
            default: begin
                a0_c = s2_mx;
                b0_c = s2_mn >> 2;
            end
        endcase
    end

    // Stage 3 register: hold the scaled terms
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s3_v   <= 1'b0;
            s3_tag <= '0;
            s3_a0  <= '0;
            s3_b0  <= '0;
            s3_a1  <= '0;
            s3_b1  <= '0;
        end else if (enable) begin
            s3_v   <= s2_v;
            s3_tag <= s2_tag;
            s3_a0  <= a0_c;
            s3_b0  <= b0_c;
            s3_a1  <= a1_c;
            s3_b1  <= b1_c;
        end
    end

    // Final sums; a zero alternate pair never wins the compare
    always_comb begin
        sum0 = {1'b0, s3_a0} + {1'b0, s3_b0};
        sum1 = {1'b0, s3_a1} + {1'b0, s3_b1};
        est  = (sum1 > sum0) ? sum1 : sum0;
    end

    // Stage 4 register: output, strobe and peak-hold
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mag     <= '0;
            mag_stb <= 1'b0;
            tag_out <= '0;
            peak    <= '0;
        end else if (enable) begin
            mag_stb <= s3_v;
            if (s3_v) begin
                mag     <= est;
                tag_out <= s3_tag;
            end
            if (peak_clear)
                peak <= s3_v ? est : '0;
            else if (s3_v && (est > peak))
                peak <= est;
        end else begin
            mag_stb <= 1'b0;
        end
    end

endmodule

// File: tb/tb_complex_mag_est.sv
// Scoreboard bench for complex_mag_est.
// Directed vectors plus a random run against a reference model.
module tb_complex_mag_est;

    logic               clock = 1'b0;
    logic               reset_n;
    logic               enable;
    logic signed [15:0] i;
    logic signed [15:0] q;
    logic [1:0]         mode;
    logic [1:0]         tag_in;
    logic               input_valid;
    logic               peak_clear;
    logic [16:0]        mag;
    logic               mag_stb;
    logic [1:0]         tag_out;
    logic [16:0]        peak;

    typedef struct {
        logic [16:0] mag;
        logic [1:0]  tag;
        int          ec;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   ecount = 0;
    logic en_q   = 1'b1;
    int   n_in   = 0;
    int   n_out  = 0;

    complex_mag_est #(.DATA_WIDTH(16), .TAG_WIDTH(2)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .i           (i),
        .q           (q),
        .mode        (mode),
        .tag_in      (tag_in),
        .input_valid (input_valid),
        .peak_clear  (peak_clear),
        .mag         (mag),
        .mag_stb     (mag_stb),
        .tag_out     (tag_out),
        .peak        (peak)
    );

    always #5 clock = ~clock;

    // Count enabled edges so the monitor can measure latency
    always @(posedge clock) begin
        en_q <= enable;
        if (reset_n && enable)
            ecount <= ecount + 1;
    end

    function automatic logic [16:0] model(int si, int sq, int m);
        int ai, aq, mx, mn, r, r2;
        ai = (si < 0) ? -si : si;
        aq = (sq < 0) ? -sq : sq;
        if (ai > 32767) ai = 32767;
        if (aq > 32767) aq = 32767;
        mx = (ai > aq) ? ai : aq;
        mn = (ai > aq) ? aq : ai;
        case (m)
            0: r = mx + mn / 4;
            1: r = mx + mn / 2;
            2: r = (mx - mx / 16) + (mn / 2 - mn / 32);
            default: begin
                r  = mx + mn / 4;
                r2 = (mx - mx / 8) + mn / 2;
                if (r2 > r) r = r2;
            end
        endcase
        return 17'(r);
    endfunction

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Present one sample for one cycle; queue expectation if it will be taken
    task automatic send(int si, int sq, int m, int t, int e, bit en);
        exp_t x;
        enable      = en;
        i           = 16'(si);
        q           = 16'(sq);
        mode        = 2'(m);
        tag_in      = 2'(t);
        input_valid = 1'b1;
        if (en) begin
            x.mag = 17'(e);
            x.tag = 2'(t);
            x.ec  = ecount;
            sbq.push_back(x);
            n_in++;
        end
        @(negedge clock);
        input_valid = 1'b0;
        enable      = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("drain_pending", sbq.size(), 0);
        sbq.delete();
    endtask

    // Monitor: pop and compare on every strobe
    always @(negedge clock) begin
        exp_t x;
        if (reset_n && mag_stb) begin
            n_out++;
            if (!en_q)
                check("stb_while_disabled", 1, 0);
            if (sbq.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                x = sbq.pop_front();
                check("mag", int'(mag), int'(x.mag));
                check("tag", int'(tag_out), int'(x.tag));
                check("latency", ecount - x.ec, 4);
            end
        end
    end

    initial begin
        int s, ri, rq, rm, rt;
        bit en;
        reset_n     = 1'b0;
        enable      = 1'b1;
        i           = '0;
        q           = '0;
        mode        = '0;
        tag_in      = '0;
        input_valid = 1'b0;
        peak_clear  = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_mag", int'(mag), 0);
        check("reset_stb", int'(mag_stb), 0);
        check("reset_peak", int'(peak), 0);
        reset_n = 1'b1;
        @(negedge clock);

        // Mode sweep on one sample
        send(3000, 4000, 0, 0, 4750, 1);
        send(3000, 4000, 1, 1, 5500, 1);
        send(3000, 4000, 2, 2, 5157, 1);
        send(3000, 4000, 3, 3, 5000, 1);
        drain();

        // Saturation and extreme inputs
        send(-32768, 0, 0, 1, 32767, 1);
        send(-32768, -32768, 1, 2, 49150, 1);
        send(32767, 32767, 3, 3, 45055, 1);
        send(0, 0, 2, 0, 0, 1);
        drain();

        // Enable low for two clocks mid-stream, valid held high
        s = 0;
        for (int c = 0; c < 10; c++) begin
            en = !(c == 3 || c == 4);
            send(1000 + s * 100, s * 50, 1, s % 4,
                 1000 + s * 100 + (s * 50) / 2, en);
            if (en) s++;
        end
        drain();
        check("en_sample_count", s, 8);

        // Reset with three samples in flight
        send(20000, 100, 0, 1, 20025, 1);
        send(20001, 100, 0, 2, 20026, 1);
        send(20002, 100, 0, 3, 20027, 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_mag", int'(mag), 0);
        check("async_stb", int'(mag_stb), 0);
        check("async_tag", int'(tag_out), 0);
        check("async_peak", int'(peak), 0);
        sbq.delete();
        n_in = 0;
        n_out = 0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);
        check("strobes_after_reset", n_out, 0);

        // Peak-hold
        send(100, 0, 0, 0, 100, 1);
        send(500, 0, 0, 1, 500, 1);
        send(200, 0, 0, 2, 200, 1);
        drain();
        check("peak_max", int'(peak), 500);
        send(50, 0, 0, 3, 50, 1);
        @(negedge clock);
        @(negedge clock);
        peak_clear = 1'b1;
        @(negedge clock);
        peak_clear = 1'b0;
        check("peak_clear_stb", int'(peak), 50);
        drain();
        peak_clear = 1'b1;
        @(negedge clock);
        peak_clear = 1'b0;
        check("peak_clear_idle", int'(peak), 0);

        // Random run against the model
        n_in = 0;
        n_out = 0;
        for (int k = 0; k < 10000; k++) begin
            ri = int'($urandom_range(0, 65535)) - 32768;
            rq = int'($urandom_range(0, 65535)) - 32768;
            if ($urandom_range(0, 31) == 0) ri = -32768;
            if ($urandom_range(0, 31) == 0) rq = ri;
            rm = int'($urandom_range(0, 3));
            rt = int'($urandom_range(0, 3));
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) begin
                enable = en;
                @(negedge clock);
                enable = 1'b1;
            end else begin
                send(ri, rq, rm, rt, int'(model(ri, rq, rm)), en);
            end
        end
        drain();
        check("random_strobe_count", n_out, n_in);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
